// File: rtl/id_stage_pipe_if.sv
// Handshake/bundle bus between if_id, the decode stage and id_ex.
// slave is the decode stage view, master is the surrounding pipeline view.
interface id_stage_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst_i;
    logic [31:0]      inst_addr_i;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst_o;
    logic [31:0]      inst_addr_o;
    logic [XLEN-1:0]  op1_o;
    logic [XLEN-1:0]  op2_o;
    logic [3:0]       alu_op_o;
    logic [4:0]       rd_addr_o;
    logic             reg_wen;
    logic             illegal_o;
    logic [CNT_W-1:0] dec_cnt_o;

    modport slave (
        input  in_valid, inst_i, inst_addr_i, out_ready,
        output in_ready, out_valid, inst_o, inst_addr_o, op1_o, op2_o,
               alu_op_o, rd_addr_o, reg_wen, illegal_o, dec_cnt_o
    );

    modport master (
        output in_valid, inst_i, inst_addr_i, out_ready,
        input  in_ready, out_valid, inst_o, inst_addr_o, op1_o, op2_o,
               alu_op_o, rd_addr_o, reg_wen, illegal_o, dec_cnt_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage (OP-IMM, OP, LUI, AUIPC) with EX/WB operand
// forwarding, valid/ready handshakes, flush and a saturating accept counter.
module id_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    id_stage_pipe_if.slave  bus,
    input  logic            flush,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            ex_wen,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [31:0]     inst;
        logic [31:0]     pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      alu;
        logic [4:0]      rd;
        logic            wen;
        logic            ill;
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{inst: 32'h0000_0013, default: '0};

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    assign inst   = bus.inst_i;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Base ALU op for funct3 when funct7 selects the normal variant
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    base_alu = 4'd0;
            3'd1:    base_alu = 4'd2;
            3'd2:    base_alu = 4'd3;
            3'd3:    base_alu = 4'd4;
            3'd4:    base_alu = 4'd5;
            3'd5:    base_alu = 4'd6;
            3'd6:    base_alu = 4'd8;
            default: base_alu = 4'd9;
        endcase
    endfunction

    // Register-file read addresses follow the opcode; unused fields read x0
    always_comb begin
        rs1_addr_o = 5'd0;
        rs2_addr_o = 5'd0;
        if (opcode == OPC_OP_IMM || opcode == OPC_OP) begin
            rs1_addr_o = inst[19:15];
        end
        if (opcode == OPC_OP) begin
            rs2_addr_o = inst[24:20];
        end
    end

    logic [XLEN-1:0] fwd1_c;
    logic [XLEN-1:0] fwd2_c;

    assign fwd1_c = (rs1_addr_o == 5'd0)               ? '0      :
                    (ex_wen && ex_rd == rs1_addr_o)    ? ex_data :
                    (wb_wen && wb_rd == rs1_addr_o)    ? wb_data : rs1_data_i;
    assign fwd2_c = (rs2_addr_o == 5'd0)               ? '0      :
                    (ex_wen && ex_rd == rs2_addr_o)    ? ex_data :
                    (wb_wen && wb_rd == rs2_addr_o)    ? wb_data : rs2_data_i;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign shamt = XLEN'(inst[24:20]);

    bundle_t         dec_c;
    logic            legal;
    logic [3:0]      alu;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    always_comb begin
        legal = 1'b0;
        alu   = ALU_ADD;
        op1   = '0;
        op2   = '0;
        case (opcode)
            OPC_OP_IMM: begin
                op1   = fwd1_c;
                op2   = imm_i;
                alu   = base_alu(funct3);
                legal = 1'b1;
                if (funct3 == 3'd1) begin
                    op2   = shamt;
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == 3'd5) begin
                    op2 = shamt;
                    if (funct7 == F7_ALT) alu = ALU_SRA;
                    else                  legal = (funct7 == F7_BASE);
                end
            end
            OPC_OP: begin
                op1 = fwd1_c;
                op2 = fwd2_c;
                if (funct7 == F7_BASE) begin
                    alu   = base_alu(funct3);
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    alu   = ALU_SUB;
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    alu   = ALU_SRA;
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                op2   = imm_u;
                alu   = ALU_PASSB;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                op1   = XLEN'(bus.inst_addr_i);
                op2   = imm_u;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings still travel down the pipe, but as a harmless bundle
        dec_c.inst = inst;
        dec_c.pc   = bus.inst_addr_i;
        dec_c.op1  = legal ? op1 : '0;
        dec_c.op2  = legal ? op2 : '0;
        dec_c.alu  = legal ? alu : ALU_ADD;
        dec_c.rd   = legal ? inst[11:7] : 5'd0;
        dec_c.wen  = legal;
        dec_c.ill  = !legal;
    end

    logic             valid_q, valid_d;
    bundle_t          bundle_q, bundle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_c;

    assign bus.in_ready = !flush && (!valid_q || bus.out_ready);
    assign accept_c     = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        cnt_d    = cnt_q;
        if (accept_c) begin
            valid_d  = 1'b1;
            bundle_d = dec_c;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.out_ready || flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= BUNDLE_RST;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.inst_o      = bundle_q.inst;
    assign bus.inst_addr_o = bundle_q.pc;
    assign bus.op1_o       = bundle_q.op1;
    assign bus.op2_o       = bundle_q.op2;
    assign bus.alu_op_o    = bundle_q.alu;
    assign bus.rd_addr_o   = bundle_q.rd;
    assign bus.reg_wen     = bundle_q.wen;
    assign bus.illegal_o   = bundle_q.ill;
    assign bus.dec_cnt_o   = cnt_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized
// traffic compared against a behavioural decode/handshake model.
module tb_id_stage_pipe;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] rs1_data, rs2_data, ex_data, wb_data;
    logic        ex_wen, wb_wen;
    logic [4:0]  ex_rd, wb_rd;
    logic [4:0]  rs1_addr, rs2_addr, rs1_addr2, rs2_addr2;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    id_stage_pipe_if #(.XLEN(XLEN), .CNT_W(2))     bus2 ();

    id_stage_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    id_stage_pipe #(.XLEN(XLEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(flush),
        .rs1_addr_o(rs1_addr2), .rs2_addr_o(rs2_addr2),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } bnd_t;

    int   checks = 0;
    int   errors = 0;
    bit   m_valid;
    bnd_t m_b;
    int   m_cnt;
    bit   last_acc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0)                return 32'd0;
        if (ex_wen && ex_rd == rs)     return ex_data;
        if (wb_wen && wb_rd == rs)     return wb_data;
        return rf;
    endfunction

    // Register-file addresses an instruction actually reads, {rs1, rs2}
    function automatic logic [9:0] ref_rs(input logic [31:0] inst);
        if (inst[6:0] == 7'h33) return {inst[19:15], inst[24:20]};
        if (inst[6:0] == 7'h13) return {inst[19:15], 5'd0};
        return 10'd0;
    endfunction

    function automatic bnd_t ref_dec(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
        bnd_t        r;
        int          alu_of_f3 [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immi, immu, sh, o1, o2;
        int          alu;
        bit          ok;
        alu_of_f3 = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3   = inst[14:12];
        f7   = inst[31:25];
        immi = {{20{inst[31]}}, inst[31:20]};
        immu = {inst[31:12], 12'h000};
        sh   = {27'd0, inst[24:20]};
        ok = 0; alu = 0; o1 = 0; o2 = 0;
        case (inst[6:0])
            7'h13: begin
                o1 = a; alu = alu_of_f3[f3];
                if (f3 == 3'd1)      begin o2 = sh; ok = (f7 == 7'h00); end
                else if (f3 == 3'd5) begin o2 = sh; ok = (f7 == 7'h00) || (f7 == 7'h20);
                                           if (f7 == 7'h20) alu = 7; end
                else                 begin o2 = immi; ok = 1; end
            end
            7'h33: begin
                o1 = a; o2 = b;
                if (f7 == 7'h00)                     begin ok = 1; alu = alu_of_f3[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd0)  begin ok = 1; alu = 1; end
                else if (f7 == 7'h20 && f3 == 3'd5)  begin ok = 1; alu = 7; end
            end
            7'h37: begin ok = 1; o2 = immu; alu = 10; end
            7'h17: begin ok = 1; o1 = pc; o2 = immu; alu = 0; end
            default: ok = 0;
        endcase
        r.inst = inst;
        r.pc   = pc;
        r.op1  = ok ? o1 : 32'd0;
        r.op2  = ok ? o2 : 32'd0;
        r.alu  = ok ? 4'(alu) : 4'd0;
        r.rd   = ok ? inst[11:7] : 5'd0;
        r.wen  = ok;
        r.ill  = !ok;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_cnt   = 0;
        m_b     = '{inst: 32'h13, pc: 0, op1: 0, op2: 0, alu: 0, rd: 0, wen: 0, ill: 0};
    endtask

    task automatic check_outs();
        chk("out_valid", bus.out_valid,   m_valid);
        chk("inst_o",    bus.inst_o,      m_b.inst);
        chk("pc_o",      bus.inst_addr_o, m_b.pc);
        chk("op1",       bus.op1_o,       m_b.op1);
        chk("op2",       bus.op2_o,       m_b.op2);
        chk("alu",       bus.alu_op_o,    m_b.alu);
        chk("rd",        bus.rd_addr_o,   m_b.rd);
        chk("reg_wen",   bus.reg_wen,     m_b.wen);
        chk("illegal",   bus.illegal_o,   m_b.ill);
        chk("dec_cnt",   bus.dec_cnt_o,   m_cnt);
    endtask

    // One clock: inputs were set after the previous negedge
    task automatic cycle();
        logic [9:0] rs;
        bit         rdy, acc;
        bnd_t       nb;
        #1;
        rs  = ref_rs(bus.inst_i);
        chk("rs1_addr", rs1_addr, rs[9:5]);
        chk("rs2_addr", rs2_addr, rs[4:0]);
        rdy = !flush && (!m_valid || bus.out_ready);
        chk("in_ready", bus.in_ready, rdy);
        acc = bus.in_valid && rdy;
        nb  = ref_dec(bus.inst_i, bus.inst_addr_i,
                      ref_fwd(rs[9:5], rs1_data), ref_fwd(rs[4:0], rs2_data));
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1;
            m_b     = nb;
            m_cnt   = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
        end else if (bus.out_ready || flush) begin
            m_valid = 0;
        end
        check_outs();
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bus.in_valid    = v;
        bus.inst_i      = inst;
        bus.inst_addr_i = pc;
        bus.out_ready   = ordy;
        flush           = fl;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [4:0] r1, r2, rd;
        logic [31:0] w;
        case ($urandom % 5)
            0: opc = 7'h13;
            1: opc = 7'h33;
            2: opc = 7'h37;
            3: opc = 7'h17;
            default: opc = 7'($urandom);
        endcase
        case ($urandom % 3)
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        r1 = 5'($urandom % 4);
        r2 = 5'($urandom % 4);
        rd = 5'($urandom);
        w  = {f7, r2, r1, f3, rd, opc};
        if (opc == 7'h37 || opc == 7'h17) w = {$urandom() >> 0} & 32'hFFFF_F000 | {20'd0, rd, opc};
        return w;
    endfunction

    initial begin
        int          cnt_keep;
        bit          hold;
        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        rs1_data = 0; rs2_data = 0; ex_data = 0; wb_data = 0;
        ex_wen = 0; wb_wen = 0; ex_rd = 0; wb_rd = 0;
        bus2.in_valid = 0; bus2.inst_i = 0; bus2.inst_addr_i = 0; bus2.out_ready = 0;
        model_reset();
        last_acc = 0;
        #12;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        drive(1, 32'h0050_0093, 32'h100, 1, 0);
        cycle();
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_op2", bus.op2_o, 5);
        chk("addi_rd", bus.rd_addr_o, 1);
        chk("addi_cnt", bus.dec_cnt_o, 1);

        // sub x3,x1,x2 with x2 from EX and x1 from WB
        rs1_data = 10; rs2_data = 3;
        ex_wen = 1; ex_rd = 2; ex_data = 7;
        wb_wen = 1; wb_rd = 1; wb_data = 9;
        drive(1, 32'h4020_81B3, 32'h104, 1, 0);
        cycle();
        chk("sub_op1", bus.op1_o, 9);
        chk("sub_op2", bus.op2_o, 7);
        chk("sub_alu", bus.alu_op_o, 1);
        chk("sub_rd", bus.rd_addr_o, 3);
        ex_wen = 0; wb_wen = 0;

        drive(0, 32'h0, 32'h0, 1, 0);
        cycle();

        // lui accepted, then srai waits through a 3-cycle stall
        drive(1, 32'h1234_52B7, 32'h108, 0, 0);
        cycle();
        drive(1, 32'h4030_D313, 32'h10C, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_op2", bus.op2_o, 32'h1234_5000);
            chk("stall_alu", bus.alu_op_o, 10);
        end
        bus.out_ready = 1;
        cycle();
        chk("srai_alu", bus.alu_op_o, 7);
        chk("srai_op2", bus.op2_o, 3);

        drive(1, 32'h2020_81B3, 32'h110, 1, 0);
        cycle();
        chk("bad_f7_ill", bus.illegal_o, 1);
        chk("bad_f7_wen", bus.reg_wen, 0);
        drive(1, 32'h0000_007F, 32'h114, 1, 0);
        cycle();
        chk("bad_opc_ill", bus.illegal_o, 1);

        // Flush while a bundle is held and a new instruction is offered
        drive(1, 32'h1234_52B7, 32'h118, 0, 0);
        cycle();
        cnt_keep = m_cnt;
        drive(1, 32'h0050_0093, 32'h11C, 0, 1);
        cycle();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_cnt", bus.dec_cnt_o, cnt_keep);

        // Async reset in the middle of a stall
        drive(1, 32'h1234_52B7, 32'h120, 0, 0);
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_inst", bus.inst_o, 32'h13);
        chk("rst_op2", bus.op2_o, 0);
        chk("rst_cnt", bus.dec_cnt_o, 0);
        model_reset();
        check_outs();
        drive(0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                bus.in_valid    = ($urandom % 4) != 0;
                bus.inst_i      = gen_inst();
                bus.inst_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            bus.out_ready = ($urandom % 3) != 0;
            flush    = ($urandom % 10) == 0;
            rs1_data = $urandom; rs2_data = $urandom;
            ex_wen   = 1'($urandom); ex_rd = 5'($urandom % 4); ex_data = $urandom;
            wb_wen   = 1'($urandom); wb_rd = 5'($urandom % 4); wb_data = $urandom;
            cycle();
            hold = bus.in_valid && !last_acc;
        end
        drive(0, 32'h0, 32'h0, 1, 0);

        // Narrow counter saturates at 3
        bus2.in_valid = 1; bus2.inst_i = 32'h0050_0093; bus2.inst_addr_i = 32'h200;
        bus2.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("cnt2", bus2.dec_cnt_o, (i + 1 > 3) ? 3 : i + 1);
        end
        chk("cnt2_rs1", rs1_addr2, 0);
        chk("cnt2_rs2", rs2_addr2, 0);
        bus2.in_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
